// File: rtl/dot_accumulator.sv
// Dot-product accumulator fed by a fixed-latency multiply-add stage.
// A local valid delay line tags the cycles where c_in carries a term issued LAT cycles earlier.
module dot_accumulator #(
    parameter int LAT   = 2,
    parameter int ACC_W = 40,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      c_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [LAT-1:0]     r_vpipe;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovf;

    logic               w_tag;
    logic               w_accept;
    logic               w_add;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic [SUM_W-1:0]   w_sum;

    assign w_tag     = r_vpipe[LAT-1];
    assign w_accept  = start && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
    assign w_add     = (r_state == S_ACCUM) && w_tag;
    assign w_cnt_inc = r_cnt + LEN_W'(1);
    // Extra top bit of the sum is the carry out of the accumulator.
    assign w_sum     = SUM_W'(r_acc) + SUM_W'(c_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_add && (w_cnt_inc == r_len)) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        w_next = (len == '0) ? S_HOLD : S_ACCUM;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vpipe <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_vpipe <= (r_vpipe << 1) | LAT'(in_valid);
            if (w_accept) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_len <= len;
                r_ovf <= 1'b0;
            end else if (w_add) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_cnt <= w_cnt_inc;
                if (w_sum[ACC_W]) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_HOLD);
    assign result    = r_acc;
    assign ovf       = r_ovf;

endmodule
